// File: rtl/mult_booth_seq_if.sv
// Multiplier request/response bundle: the requester drives the start pulse
// and operands; the multiplier returns the result, overflow flag and ready.
interface mult_booth_seq_if;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/mult_booth_seq.sv
// Sequential 32x32 signed radix-4 Booth multiplier: one partial-product
// accumulate per cycle through a 32-bit carry-lookahead adder, 16 iterations.

module mult_booth_seq_cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [8:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  // Four-bit lookahead blocks; block carries chain through group generate/propagate.
  // NOTE: every variable written here gets a value on every pass, so no latch is inferred.
  always_comb begin
    c  = '0;
    gc = '0;
    gc[0] = cin;
    for (int k = 0; k < 8; k++) begin
      int base;
      logic grp_g;
      logic grp_p;
      base  = 4 * k;
      c[base]     = gc[k];
      c[base + 1] = g[base] | (p[base] & gc[k]);
      c[base + 2] = g[base + 1] | (p[base + 1] & g[base])
                  | (p[base + 1] & p[base] & gc[k]);
      c[base + 3] = g[base + 2] | (p[base + 2] & g[base + 1])
                  | (p[base + 2] & p[base + 1] & g[base])
                  | (p[base + 2] & p[base + 1] & p[base] & gc[k]);
      grp_g = g[base + 3] | (p[base + 3] & g[base + 2])
            | (p[base + 3] & p[base + 2] & g[base + 1])
            | (p[base + 3] & p[base + 2] & p[base + 1] & g[base]);
      grp_p = &p[base +: 4];
      gc[k + 1] = grp_g | (grp_p & gc[k]);
    end
  end

  assign s    = p ^ c;
  assign cout = gc[8];
endmodule

module mult_booth_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  count_q;
  logic [31:0] mcand_q;
  logic [66:0] prod_q;
  logic [31:0] result_q;
  logic        exc_q;
  logic        rdy_q;

  logic [33:0] mcand_ext;
  logic [33:0] mag;
  logic        neg;
  logic [33:0] addend;
  logic [31:0] cla_sum;
  logic        cla_cout;
  logic [1:0]  sum_hi;
  logic [33:0] acc_sum;
  logic [66:0] prod_d;

  assign mcand_ext = {{2{mcand_q[31]}}, mcand_q};

  always_comb begin
    mag = '0;
    neg = 1'b0;
    unique case (prod_q[2:0])
      3'b001, 3'b010: mag = mcand_ext;
      3'b011:         mag = mcand_ext << 1;
      3'b100: begin
        mag = mcand_ext << 1;
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = mcand_ext;
        neg = 1'b1;
      end
      default:        mag = '0;
    endcase
  end

  // Subtraction is ones-complement of the multiple plus a carry-in of one.
  assign addend = neg ? ~mag : mag;

  mult_booth_seq_cla32 u_cla (
    .a    (prod_q[64:33]),
    .b    (addend[31:0]),
    .cin  (neg),
    .s    (cla_sum),
    .cout (cla_cout)
  );

  assign sum_hi  = prod_q[66:65] + addend[33:32] + {1'b0, cla_cout};
  assign acc_sum = {sum_hi, cla_sum};
  assign prod_d  = {{2{acc_sum[33]}}, acc_sum, prod_q[32:2]};

  // A start pulse loads in every state, which covers both abort-on-restart and back-to-back issue.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      rdy_q <= 1'b0;
      if (ctrl_MULT) begin
        state_q <= RUN;
        count_q <= '0;
        mcand_q <= data_operandA;
        prod_q  <= {34'b0, data_operandB, 1'b0};
      end else begin
        unique case (state_q)
          IDLE: state_q <= IDLE;
          RUN: begin
            prod_q  <= prod_d;
            count_q <= count_q + 4'd1;
            if (count_q == 4'd15) begin
              state_q  <= DONE;
              result_q <= prod_d[32:1];
              exc_q    <= (prod_d[64:33] != {32{prod_d[32]}});
              rdy_q    <= 1'b1;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed bench for mult_booth_seq: latency, signed products, overflow flag,
// restart, reset mid-run.
module tb_mult_booth_seq;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  mult_booth_seq_if bus ();

  mult_booth_seq dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (bus.ctrl_MULT),
    .data_operandA  (bus.data_operandA),
    .data_operandB  (bus.data_operandB),
    .data_result    (bus.data_result),
    .data_exception (bus.data_exception),
    .data_resultRDY (bus.data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Load edge is E0; ready must first be seen after E16.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc);
    int edges;
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = 1'b1;
    tick();
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = 32'hDEAD_BEEF;
    bus.data_operandB = 32'h1234_5678;
    edges = 0;
    while (!bus.data_resultRDY && edges < 40) begin
      tick();
      edges++;
    end
    check({tag, "_latency"}, edges, 32'd16);
    check({tag, "_result"}, bus.data_result, exp_res);
    check({tag, "_exc"}, {31'b0, bus.data_exception}, {31'b0, exp_exc});
  endtask

  initial begin
    logic saw_rdy;
    n_checks = 0;
    n_errors = 0;
    reset             = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    tick();
    tick();
    check("reset_result", bus.data_result, 32'd0);
    check("reset_exc", {31'b0, bus.data_exception}, 32'd0);
    check("reset_rdy", {31'b0, bus.data_resultRDY}, 32'd0);
    reset = 1'b0;
    tick();

    run_op("3x5", 32'd3, 32'd5, 32'd15, 1'b0);
    tick();
    check("3x5_rdy_one_cycle", {31'b0, bus.data_resultRDY}, 32'd0);
    check("3x5_hold", bus.data_result, 32'd15);

    run_op("m7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0);
    run_op("min_x1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
    // Issued while the previous op sits in DONE; ready must still be high then.
    check("done_rdy_high", {31'b0, bus.data_resultRDY}, 32'd1);
    run_op("min_xm1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("max_x2", 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
    run_op("p16xp16", 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1);
    run_op("5xm4", 32'd5, 32'hFFFF_FFFC, 32'hFFFF_FFEC, 1'b0);
    run_op("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("min_xmin", 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1);
    run_op("max_x3", 32'h7FFF_FFFF, 32'd3, 32'h7FFF_FFFD, 1'b1);

    // Reset at the tenth edge of a run clears outputs that were nonzero with exception set.
    tick();
    bus.data_operandA = 32'd9;
    bus.data_operandB = 32'd9;
    bus.ctrl_MULT     = 1'b1;
    tick();
    bus.ctrl_MULT = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("run_hold_result", bus.data_result, 32'h7FFF_FFFD);
    check("run_hold_exc", {31'b0, bus.data_exception}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check("midreset_result", bus.data_result, 32'd0);
    check("midreset_exc", {31'b0, bus.data_exception}, 32'd0);
    check("midreset_rdy", {31'b0, bus.data_resultRDY}, 32'd0);
    reset   = 1'b0;
    saw_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      saw_rdy = saw_rdy | bus.data_resultRDY;
    end
    check("midreset_no_rdy", {31'b0, saw_rdy}, 32'd0);
    run_op("2x2", 32'd2, 32'd2, 32'd4, 1'b0);

    // Restart: 3x5 aborted by a 4x4 load on its eighth edge.
    tick();
    bus.data_operandA = 32'd3;
    bus.data_operandB = 32'd5;
    bus.ctrl_MULT     = 1'b1;
    tick();
    bus.ctrl_MULT = 1'b0;
    saw_rdy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      saw_rdy = saw_rdy | bus.data_resultRDY;
    end
    check("restart_no_early_rdy", {31'b0, saw_rdy}, 32'd0);
    check("restart_hold", bus.data_result, 32'd4);
    run_op("restart_4x4", 32'd4, 32'd4, 32'd16, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
